// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU codes, mux selectors and the control word driven to the datapath.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_BEQ = 3'b010;
  localparam logic [2:0] ALU_BNE = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_R   = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // Dispatch target out of DECODE; S_FETCH doubles as the "illegal opcode" answer.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] func);
    case (op)
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_RTYPE:                         return (func == FUNC_JR) ? S_JR : S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_JAL:                           return S_JAL;
      default:                          return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from FSM state, opcode fields and memory
// handshake. Anything not explicitly driven in a state stays 0.
module mc_output_decode
  import mc_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       ready,
  input  logic       active,
  output ctrl_t      cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        // active keeps the PC/IR enables dead while reset holds us in FETCH
        cw.ir_write  = ready & active;
        cw.pc_write  = ready & active;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH;
        if (decode_next(op, func) == S_FETCH) begin
          cw.illegal_op = 1'b1;
          cw.instr_done = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write  = 1'b1;
        cw.iord       = 1'b1;
        cw.instr_done = ready;
      end
      S_EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.aluop     = ALU_R;
      end
      S_R_WB: begin
        cw.reg_write  = 1'b1;
        cw.reg_dst    = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: cw.aluop = ALU_AND;
          OP_ORI:  cw.aluop = ALU_OR;
          OP_LUI:  cw.aluop = ALU_LUI;
          default: cw.aluop = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a  = 1'b1;
        cw.alu_src_b  = SRCB_REG;
        cw.pc_source  = PCSRC_ALUOUT;
        cw.instr_done = 1'b1;
        if (op == OP_BNE) begin
          cw.aluop       = ALU_BNE;
          cw.pc_write_ne = 1'b1;
        end else begin
          cw.aluop       = ALU_BEQ;
          cw.pc_write_eq = 1'b1;
        end
      end
      S_JUMP, S_JAL: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCSRC_JUMP;
        cw.instr_done = 1'b1;
        cw.reg_write  = (state == S_JAL);
        cw.jal        = (state == S_JAL);
      end
      S_JR: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCSRC_RS;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register and next-state sequencing;
// the control word itself comes from mc_output_decode.
module multicycle_control
  import mc_control_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic [1:0]         pc_source,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  state_t state, nxt;
  ctrl_t  cw;
  logic   ready;

  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:    nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = decode_next(op, func);
      S_MEM_ADDR: nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   nxt = S_R_WB;
      S_EXEC_I:   nxt = S_I_WB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= nxt;
  end

  mc_output_decode u_dec (
    .state  (state),
    .op     (op),
    .func   (func),
    .ready  (ready),
    .active (reset),
    .cw     (cw)
  );

  assign pc_write    = cw.pc_write;
  assign pc_write_eq = cw.pc_write_eq;
  assign pc_write_ne = cw.pc_write_ne;
  assign pc_source   = cw.pc_source;
  assign iord        = cw.iord;
  assign mem_read    = cw.mem_read;
  assign mem_write   = cw.mem_write;
  assign ir_write    = cw.ir_write;
  assign reg_dst     = cw.reg_dst;
  assign mem_to_reg  = cw.mem_to_reg;
  assign reg_write   = cw.reg_write;
  assign jal         = cw.jal;
  assign alu_src_a   = cw.alu_src_a;
  assign alu_src_b   = cw.alu_src_b;
  assign aluop       = ALUOP_W'(cw.aluop);
  assign illegal_op  = cw.illegal_op;
  assign instr_done  = cw.instr_done;
  assign state_o     = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues per-cycle expected
// control words and instruction lengths; a negedge monitor pops and compares.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_eq, pc_write_ne;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
    logic       illegal_op, instr_done;
  } exp_t;

  logic clk = 0, reset = 0, mem_ready = 1;
  logic [5:0] op = 0, func = 0;
  logic pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, jal, alu_src_a, illegal_op, instr_done;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] aluop;
  logic [3:0] state_o;
  exp_t obs;

  int checks = 0, failures = 0, cyc = 0;
  exp_t exp_q[$];
  int   len_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .MEM_WAIT_EN(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .illegal_op(illegal_op), .instr_done(instr_done), .state_o(state_o)
  );

  assign obs = {state_o, pc_write, pc_write_eq, pc_write_ne, pc_source, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, jal, alu_src_a,
                alu_src_b, aluop, illegal_op, instr_done};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected control words, one per state, written out from the state table.
  function automatic exp_t x_fetch(input logic r);
    exp_t e; e = '0; e.st = 4'd0; e.mem_read = 1; e.alu_src_b = 2'b01;
    e.ir_write = r; e.pc_write = r; return e;
  endfunction
  function automatic exp_t x_decode(input logic ill);
    exp_t e; e = '0; e.st = 4'd1; e.alu_src_b = 2'b11;
    e.illegal_op = ill; e.instr_done = ill; return e;
  endfunction
  function automatic exp_t x_mem_addr();
    exp_t e; e = '0; e.st = 4'd2; e.alu_src_a = 1; e.alu_src_b = 2'b10; return e;
  endfunction
  function automatic exp_t x_mem_rd();
    exp_t e; e = '0; e.st = 4'd3; e.mem_read = 1; e.iord = 1; return e;
  endfunction
  function automatic exp_t x_mem_wb();
    exp_t e; e = '0; e.st = 4'd4; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; return e;
  endfunction
  function automatic exp_t x_mem_wr(input logic r);
    exp_t e; e = '0; e.st = 4'd5; e.mem_write = 1; e.iord = 1; e.instr_done = r; return e;
  endfunction
  function automatic exp_t x_exec_r();
    exp_t e; e = '0; e.st = 4'd6; e.alu_src_a = 1; e.aluop = 3'b111; return e;
  endfunction
  function automatic exp_t x_r_wb();
    exp_t e; e = '0; e.st = 4'd7; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; return e;
  endfunction
  function automatic exp_t x_exec_i(input logic [2:0] a);
    exp_t e; e = '0; e.st = 4'd8; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluop = a; return e;
  endfunction
  function automatic exp_t x_i_wb();
    exp_t e; e = '0; e.st = 4'd9; e.reg_write = 1; e.instr_done = 1; return e;
  endfunction
  function automatic exp_t x_branch(input logic ne);
    exp_t e; e = '0; e.st = 4'd10; e.alu_src_a = 1; e.pc_source = 2'b01; e.instr_done = 1;
    e.aluop = ne ? 3'b011 : 3'b010; e.pc_write_ne = ne; e.pc_write_eq = ~ne; return e;
  endfunction
  function automatic exp_t x_jump(input logic [3:0] st, input logic [1:0] src, input logic lnk);
    exp_t e; e = '0; e.st = st; e.pc_write = 1; e.pc_source = src; e.instr_done = 1;
    e.reg_write = lnk; e.jal = lnk; return e;
  endfunction

  task automatic step(input logic r, input exp_t e);
    mem_ready = r;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input int len);
    op = o; func = f; len_q.push_back(len);
  endtask

  // Monitor: compares every live cycle and the length of each retired instruction.
  always @(negedge clk) begin
    if (!reset) cyc = 0;
    else begin
      if (exp_q.size() > 0) chk("cycle_ctrl", 32'(obs), 32'(exp_q.pop_front()));
      cyc++;
      if (instr_done) begin
        if (len_q.size() > 0) chk("instr_len", cyc, len_q.pop_front());
        else begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end
        cyc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vec", 32'(obs), 32'(x_fetch(0)));
    reset = 1;

    // add
    instr(6'h00, 6'h20, 4);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_r()); step(1, x_r_wb());

    // lw with two wait cycles in MEM_RD
    instr(6'h23, 6'h00, 7);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_mem_addr());
    step(0, x_mem_rd()); step(0, x_mem_rd()); step(1, x_mem_rd()); step(1, x_mem_wb());

    // sw with one wait cycle in MEM_WR
    instr(6'h2B, 6'h00, 5);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_mem_addr());
    step(0, x_mem_wr(0)); step(1, x_mem_wr(1));

    // addi with a FETCH wait, then ori, lui, andi
    instr(6'h08, 6'h00, 5);
    step(0, x_fetch(0)); step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_i(3'b000)); step(1, x_i_wb());
    instr(6'h0D, 6'h00, 4);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_i(3'b101)); step(1, x_i_wb());
    instr(6'h0F, 6'h00, 4);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_i(3'b100)); step(1, x_i_wb());
    instr(6'h0C, 6'h00, 4);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_i(3'b001)); step(1, x_i_wb());

    // beq, bne
    instr(6'h04, 6'h00, 3);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_branch(0));
    instr(6'h05, 6'h00, 3);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_branch(1));

    // j, jal, jr
    instr(6'h02, 6'h00, 3);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_jump(4'd11, 2'b10, 0));
    instr(6'h03, 6'h00, 3);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_jump(4'd12, 2'b10, 1));
    instr(6'h00, 6'h08, 3);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_jump(4'd13, 2'b11, 0));

    // illegal opcode, then a stalled FETCH proving no stray enables follow
    instr(6'h3F, 6'h00, 2);
    step(1, x_fetch(1)); step(1, x_decode(1));
    instr(6'h00, 6'h20, 5);
    step(0, x_fetch(0)); step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_r()); step(1, x_r_wb());

    // sw aborted by reset while waiting in MEM_WR
    op = 6'h2B; func = 6'h00;
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_mem_addr()); step(0, x_mem_wr(0));
    chk("pre_reset_mem_write", 32'(mem_write), 32'd1);
    #1 reset = 0; mem_ready = 1;
    #1;
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_vec_mid", 32'(obs), 32'(x_fetch(0)));
    @(posedge clk); #1 reset = 1;

    // normal operation after reset release
    instr(6'h00, 6'h20, 4);
    step(1, x_fetch(1)); step(1, x_decode(0)); step(1, x_exec_r()); step(1, x_r_wb());

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("len_q_drained", 32'(len_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
